// File: rtl/fifo_pkg.sv
// Shared definitions for the read-side FWFT stage: output-buffer state encoding
// and the default word width.
package fifo_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        S0 = 2'd0,
        S1 = 2'd1,
        S2 = 2'd2
    } buf_state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry head/skid output buffer. Output data always comes from the head flop.
// state | meaning
// S0    | no word held
// S1    | head valid
// S2    | head and skid valid (skid holds the younger word)
module skid_buf2
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  capture,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic [1:0]            level
);

    buf_state_t            state;
    buf_state_t            state_next;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] skid;
    logic                  pop;

    assign pop  = valid & ready;
    assign data = head;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S0: if (capture) state_next = S1;
            S1: begin
                if (capture && !pop) begin
                    state_next = S2;
                end else if (!capture && pop) begin
                    state_next = S0;
                end
            end
            S2: if (pop && !capture) state_next = S1;
            default: state_next = S0;
        endcase
    end

    always_comb begin
        valid = 1'b0;
        level = 2'd0;
        case (state)
            S1: begin
                valid = 1'b1;
                level = 2'd1;
            end
            S2: begin
                valid = 1'b1;
                level = 2'd2;
            end
            default: begin
                valid = 1'b0;
                level = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            skid <= '0;
        end else begin
            case (state)
                S0: if (capture) head <= wdata;
                S1: begin
                    if (capture && pop) begin
                        head <= wdata;
                    end else if (capture) begin
                        skid <= wdata;
                    end
                end
                S2: begin
                    if (pop) begin
                        head <= skid;
                        if (capture) skid <= wdata;
                    end
                end
                default: begin
                    head <= head;
                    skid <= skid;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // The credit logic upstream must never let a word land in a full buffer.
    always @(posedge clk) begin
        assert (rst || !(state == S2 && capture && !pop))
            else $error("skid_buf2: capture into full buffer without pop");
    end
`endif

endmodule

// File: rtl/rd_fwft_stage.sv
// First-word-fall-through read stage: issues FIFO reads against a two-word credit
// and presents words from a registered head/skid buffer.
module rd_fwft_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  empty,
    output logic                  rd,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            level
);

    logic       inflight;
    logic       pop;
    logic [2:0] credit;

    assign pop = m_valid & m_ready;

    // Words held plus the one arriving, minus the one leaving this cycle.
    assign credit = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
    assign rd     = !rrst && !empty && (credit < 3'd2);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd;
        end
    end

    skid_buf2 #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_buf (
        .clk    (rclk),
        .rst    (rrst),
        .capture(inflight),
        .wdata  (rdata),
        .ready  (m_ready),
        .valid  (m_valid),
        .data   (m_data),
        .level  (level)
    );

endmodule

// File: tb/tb_rd_fwft_stage.sv
// Bench for rd_fwft_stage: queue-based reference model checked every cycle, plus
// directed scenarios with literal expectations and a direct skid_buf2 test.
module tb_rd_fwft_stage;

    localparam int W = 8;

    logic         rclk = 1'b0;
    logic         rrst = 1'b1;
    logic         empty = 1'b1;
    logic         rd;
    logic [W-1:0] rdata = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [W-1:0] m_data;
    logic [1:0]   level;

    logic         sb_rst = 1'b1;
    logic         sb_cap = 1'b0;
    logic [W-1:0] sb_wdata = '0;
    logic         sb_ready = 1'b0;
    logic         sb_valid;
    logic [W-1:0] sb_data;
    logic [1:0]   sb_level;

    always #5 rclk = ~rclk;

    rd_fwft_stage #(.DATA_WIDTH(W)) dut (
        .rclk   (rclk),
        .rrst   (rrst),
        .empty  (empty),
        .rd     (rd),
        .rdata  (rdata),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .level  (level)
    );

    skid_buf2 #(.DATA_WIDTH(W)) sb (
        .clk    (rclk),
        .rst    (sb_rst),
        .capture(sb_cap),
        .wdata  (sb_wdata),
        .ready  (sb_ready),
        .valid  (sb_valid),
        .data   (sb_data),
        .level  (sb_level)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: words held by the stage, plus whether one is arriving.
    logic [W-1:0] mq[$];
    bit           pend = 1'b0;
    bit           seen_reset = 1'b0;
    bit           fetch_seen = 1'b0;
    int           fetch_cnt = 0;
    logic [W-1:0] pop_log[$];
    logic [W-1:0] src[$];

    always @(negedge rclk) begin
        bit exp_valid;
        bit exp_pop;
        bit exp_rd;
        int credit;
        exp_valid = mq.size() > 0;
        exp_pop   = exp_valid && m_ready;
        credit    = mq.size() + int'(pend) - int'(exp_pop);
        exp_rd    = !rrst && !empty && credit < 2;
        if (rrst || seen_reset) check("model_rd", {31'd0, rd}, {31'd0, exp_rd});
        if (seen_reset) begin
            check("model_m_valid", {31'd0, m_valid}, {31'd0, exp_valid});
            check("model_level", {30'd0, level}, mq.size());
            if (exp_valid) check("model_m_data", {24'd0, m_data}, {24'd0, mq[0]});
        end
        fetch_seen = rd && !empty;
        if (fetch_seen) fetch_cnt++;
        if (m_valid === 1'b1 && m_ready) pop_log.push_back(m_data);
        if (rrst) begin
            mq.delete();
            pend = 1'b0;
            seen_reset = 1'b1;
        end else begin
            if (exp_pop) void'(mq.pop_front());
            if (pend) mq.push_back(rdata);
            pend = exp_rd;
        end
    end

    // One cycle: memory returns the word fetched last cycle, then inputs are applied.
    task automatic cyc(input bit ready, input bit rst_i, input bit hold);
        @(posedge rclk);
        #1;
        if (fetch_seen && src.size() > 0) rdata = src.pop_front();
        else rdata = 8'hEE;
        m_ready = ready;
        rrst    = rst_i;
        empty   = (src.size() == 0) || hold;
        @(negedge rclk);
        #1;
    endtask

    initial begin
        int n;
        cyc(0, 1, 0);
        cyc(0, 1, 0);
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_level", {30'd0, level}, 32'd0);
        check("reset_m_data", {24'd0, m_data}, 32'd0);
        check("reset_rd", {31'd0, rd}, 32'd0);

        // single word with consumer stalled
        src.push_back(8'hA5);
        cyc(0, 0, 0);
        check("single_rd_c1", {31'd0, rd}, 32'd1);
        cyc(0, 0, 0);
        check("single_valid_c2", {31'd0, m_valid}, 32'd0);
        cyc(0, 0, 0);
        check("single_valid_c3", {31'd0, m_valid}, 32'd1);
        check("single_data_c3", {24'd0, m_data}, 32'hA5);
        repeat (3) cyc(0, 0, 0);
        check("single_data_hold", {24'd0, m_data}, 32'hA5);
        check("single_level", {30'd0, level}, 32'd1);
        check("single_rd_idle", {31'd0, rd}, 32'd0);
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        check("single_drained", {31'd0, m_valid}, 32'd0);

        // streaming
        for (int k = 1; k <= 16; k++) src.push_back(W'(k));
        n = 0;
        do begin
            cyc(1, 0, 0);
            n++;
        end while (m_valid !== 1'b1 && n < 10);
        check("stream_first_cycle", n, 32'd3);
        for (int k = 1; k <= 16; k++) begin
            check("stream_valid", {31'd0, m_valid}, 32'd1);
            check("stream_data", {24'd0, m_data}, k);
            cyc(1, 0, 0);
        end
        check("stream_done", {31'd0, m_valid}, 32'd0);

        // backpressure
        pop_log.delete();
        fetch_cnt = 0;
        src.push_back(8'd10);
        src.push_back(8'd11);
        src.push_back(8'd12);
        repeat (6) cyc(0, 0, 0);
        check("bp_fetches", fetch_cnt, 32'd2);
        check("bp_level", {30'd0, level}, 32'd2);
        check("bp_rd", {31'd0, rd}, 32'd0);
        check("bp_head", {24'd0, m_data}, 32'd10);
        repeat (8) cyc(1, 0, 0);
        check("bp_pop_count", pop_log.size(), 32'd3);
        for (int j = 0; j < 3 && j < pop_log.size(); j++)
            check("bp_pop_order", {24'd0, pop_log[j]}, 32'd10 + j);
        check("bp_level_end", {30'd0, level}, 32'd0);

        // empty toggling every cycle
        pop_log.delete();
        fetch_cnt = 0;
        for (int k = 0; k < 8; k++) src.push_back(W'(8'd20 + k));
        for (int i = 0; i < 24; i++) cyc(1, 0, (i % 2) == 1);
        repeat (6) cyc(1, 0, 0);
        check("tog_fetches", fetch_cnt, 32'd8);
        check("tog_pop_count", pop_log.size(), 32'd8);
        for (int j = 0; j < 8 && j < pop_log.size(); j++)
            check("tog_pop_order", {24'd0, pop_log[j]}, 32'd20 + j);

        // reset with a word in flight
        pop_log.delete();
        src.push_back(8'h3C);
        cyc(1, 0, 0);
        check("mfr_fetch", {31'd0, rd}, 32'd1);
        cyc(1, 1, 0);
        cyc(1, 0, 0);
        check("mfr_m_valid", {31'd0, m_valid}, 32'd0);
        check("mfr_level", {30'd0, level}, 32'd0);
        check("mfr_m_data", {24'd0, m_data}, 32'd0);
        repeat (4) cyc(1, 0, 0);
        check("mfr_never_presented", pop_log.size(), 32'd0);
        check("mfr_still_empty", {31'd0, m_valid}, 32'd0);

        // buffer alone: pop and capture together while full
        sb_rst = 1'b1;
        cyc(0, 0, 0);
        sb_rst = 1'b0; sb_cap = 1'b1; sb_wdata = 8'd6; sb_ready = 1'b0;
        cyc(0, 0, 0);
        check("sb_s1_level", {30'd0, sb_level}, 32'd1);
        check("sb_s1_data", {24'd0, sb_data}, 32'd6);
        sb_wdata = 8'd7;
        cyc(0, 0, 0);
        check("sb_s2_level", {30'd0, sb_level}, 32'd2);
        check("sb_s2_data", {24'd0, sb_data}, 32'd6);
        sb_wdata = 8'd8; sb_ready = 1'b1;
        cyc(0, 0, 0);
        check("sb_popcap_level", {30'd0, sb_level}, 32'd2);
        check("sb_popcap_head", {24'd0, sb_data}, 32'd7);
        sb_cap = 1'b0;
        cyc(0, 0, 0);
        check("sb_skid_word", {24'd0, sb_data}, 32'd8);
        check("sb_skid_level", {30'd0, sb_level}, 32'd1);
        cyc(0, 0, 0);
        check("sb_drained", {31'd0, sb_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
